// File: rtl/shift_logic_4.sv
// 4-bit one-hot-select left shifter: combinational result and select check,
// plus a registered copy of the result and a sticky error flag.
module shift_logic_4 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] datain,
  input  logic [3:0] shift,
  output logic [3:0] dataout,
  output logic       shift_err,
  output logic [3:0] dataout_q,
  output logic       err_sticky
);

  logic       shift_nonzero;
  logic       shift_single;

  // AND-OR mux: each select bit contributes its own zero-filled shifted copy,
  // so a multi-hot select ORs several copies together.
  always_comb begin
    dataout = 4'b0000;
    if (shift[0]) dataout = dataout | datain;
    if (shift[1]) dataout = dataout | {datain[2:0], 1'b0};
    if (shift[2]) dataout = dataout | {datain[1:0], 2'b00};
    if (shift[3]) dataout = dataout | {datain[0], 3'b000};
  end

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  always_comb begin
    shift_nonzero = (shift != 4'b0000);
    shift_single  = ((shift & (shift - 4'd1)) == 4'b0000);
    shift_err     = !(shift_nonzero && shift_single);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataout_q  <= 4'b0000;
      err_sticky <= 1'b0;
    end else begin
      dataout_q <= dataout;
      if (shift_err) err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_shift_logic_4.sv
// Directed bench for shift_logic_4: combinational shift/err, register path,
// sticky flag and asynchronous reset behaviour.
module tb_shift_logic_4;

  logic       clk;
  logic       rst;
  logic [3:0] datain;
  logic [3:0] shift;
  logic [3:0] dataout;
  logic       shift_err;
  logic [3:0] dataout_q;
  logic       err_sticky;

  int errors = 0;
  int checks = 0;

  shift_logic_4 dut (
    .clk        (clk),
    .rst        (rst),
    .datain     (datain),
    .shift      (shift),
    .dataout    (dataout),
    .shift_err  (shift_err),
    .dataout_q  (dataout_q),
    .err_sticky (err_sticky)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst    = 1'b1;
    datain = 4'b0000;
    shift  = 4'b0001;
    #2;
    checks++;
    if (dataout_q !== 4'b0000) begin
      errors++;
      $display("FAIL reset_dataout_q: got %b expected 0000", dataout_q);
    end
    checks++;
    if (err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset_err_sticky: got %b expected 0", err_sticky);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_walking_one();
    logic [3:0] sel [4];
    logic [3:0] exp [4];
    sel = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    datain = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      shift = sel[i];
      #5;
      checks++;
      if (dataout !== exp[i]) begin
        errors++;
        $display("FAIL walk_dataout[%0d]: got %b expected %b", i, dataout, exp[i]);
      end
      checks++;
      if (shift_err !== 1'b0) begin
        errors++;
        $display("FAIL walk_shift_err[%0d]: got %b expected 0", i, shift_err);
      end
    end
    @(negedge clk);
    checks++;
    if (err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL walk_err_sticky: got %b expected 0", err_sticky);
    end
  endtask

  task automatic test_truncation();
    datain = 4'b1011;
    shift  = 4'b0100;
    #1;
    checks++;
    if (dataout !== 4'b1100) begin
      errors++;
      $display("FAIL trunc_shift2: got %b expected 1100", dataout);
    end
    shift = 4'b1000;
    #1;
    checks++;
    if (dataout !== 4'b1000) begin
      errors++;
      $display("FAIL trunc_shift3: got %b expected 1000", dataout);
    end
  endtask

  task automatic test_register_path();
    @(negedge clk);
    datain = 4'b0000;
    shift  = 4'b0001;
    @(negedge clk);
    datain = 4'b0011;
    shift  = 4'b0010;
    #1;
    checks++;
    if (dataout_q !== 4'b0000) begin
      errors++;
      $display("FAIL reg_before_edge: got %b expected 0000", dataout_q);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dataout_q !== 4'b0110) begin
      errors++;
      $display("FAIL reg_after_edge: got %b expected 0110", dataout_q);
    end
    checks++;
    if (err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL reg_err_sticky: got %b expected 0", err_sticky);
    end
  endtask

  task automatic test_zero_select();
    @(negedge clk);
    datain = 4'b1111;
    shift  = 4'b0000;
    #1;
    checks++;
    if (dataout !== 4'b0000) begin
      errors++;
      $display("FAIL zero_dataout: got %b expected 0000", dataout);
    end
    checks++;
    if (shift_err !== 1'b1) begin
      errors++;
      $display("FAIL zero_shift_err: got %b expected 1", shift_err);
    end
    checks++;
    if (err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL zero_sticky_before_edge: got %b expected 0", err_sticky);
    end
    @(posedge clk);
    #1;
    checks++;
    if (err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL zero_sticky_after_edge: got %b expected 1", err_sticky);
    end
    @(negedge clk);
    shift = 4'b0001;
    @(posedge clk);
    #1;
    checks++;
    if (err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL sticky_hold: got %b expected 1", err_sticky);
    end
  endtask

  task automatic test_multi_hot();
    datain = 4'b0001;
    shift  = 4'b0011;
    #1;
    checks++;
    if (dataout !== 4'b0011) begin
      errors++;
      $display("FAIL multi_dataout: got %b expected 0011", dataout);
    end
    checks++;
    if (shift_err !== 1'b1) begin
      errors++;
      $display("FAIL multi_shift_err: got %b expected 1", shift_err);
    end
    datain = 4'b0101;
    shift  = 4'b1010;
    #1;
    checks++;
    if (dataout !== 4'b1010) begin
      errors++;
      $display("FAIL multi2_dataout: got %b expected 1010", dataout);
    end
  endtask

  // Every datain/shift pair against a per-output-bit convolution model.
  task automatic test_exhaustive();
    logic [3:0] exp_d;
    logic       exp_e;
    int         ones;
    for (int s = 0; s < 16; s++) begin
      for (int d = 0; d < 16; d++) begin
        datain = d[3:0];
        shift  = s[3:0];
        exp_d  = 4'b0000;
        ones   = 0;
        for (int k = 0; k < 4; k++) if (s[k]) ones++;
        for (int i = 0; i < 4; i++)
          for (int k = 0; k <= i; k++)
            if (s[k] && d[i-k]) exp_d[i] = 1'b1;
        exp_e = (ones != 1);
        #1;
        checks++;
        if (dataout !== exp_d || shift_err !== exp_e) begin
          errors++;
          $display("FAIL exhaustive d=%b s=%b: got %b/%b expected %b/%b",
                   d[3:0], s[3:0], dataout, shift_err, exp_d, exp_e);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    datain = 4'b0011;
    shift  = 4'b0010;
    @(posedge clk);
    #1;
    checks++;
    if (dataout_q !== 4'b0110 || err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL areset_setup: got %b/%b expected 0110/1", dataout_q, err_sticky);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (dataout_q !== 4'b0000) begin
      errors++;
      $display("FAIL areset_dataout_q: got %b expected 0000", dataout_q);
    end
    checks++;
    if (err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL areset_err_sticky: got %b expected 0", err_sticky);
    end
    checks++;
    if (dataout !== 4'b0110) begin
      errors++;
      $display("FAIL areset_comb_hold: got %b expected 0110", dataout);
    end
    datain = 4'b0001;
    #1;
    checks++;
    if (dataout !== 4'b0010) begin
      errors++;
      $display("FAIL areset_comb_track: got %b expected 0010", dataout);
    end
    // error present while reset is held: reset must win
    shift = 4'b0000;
    @(posedge clk);
    #1;
    checks++;
    if (err_sticky !== 1'b0 || dataout_q !== 4'b0000) begin
      errors++;
      $display("FAIL reset_wins: got %b/%b expected 0000/0", dataout_q, err_sticky);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    rst    = 1'b0;
    datain = 4'b0101;
    shift  = 4'b0001;
    @(posedge clk);
    #1;
    checks++;
    if (dataout_q !== 4'b0101 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got %b/%b expected 0101/0", dataout_q, err_sticky);
    end
    @(negedge clk);
    datain = 4'b0111;
    shift  = 4'b0100;
    @(posedge clk);
    #1;
    checks++;
    if (dataout_q !== 4'b1100) begin
      errors++;
      $display("FAIL b2b_second: got %b expected 1100", dataout_q);
    end
    @(negedge clk);
    datain = 4'b1001;
    shift  = 4'b1000;
    @(posedge clk);
    #1;
    checks++;
    if (dataout_q !== 4'b1000 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL b2b_third: got %b/%b expected 1000/0", dataout_q, err_sticky);
    end
  endtask

  initial begin
    test_reset();
    test_walking_one();
    test_truncation();
    test_register_path();
    test_zero_select();
    test_multi_hot();
    test_exhaustive();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
